// File: rtl/winner_banner_anim.sv
// End-of-game "END" banner overlay: latches winner/column on game over, slides the
// glyph down to a target row, blinks it, then holds. Registered per-pixel hit output.
module winner_banner_anim #(
    parameter int SCALE_LOG2    = 0,
    parameter int COL_PITCH     = 92,
    parameter int X_OFFSET      = 10,
    parameter int H_ACTIVE      = 640,
    parameter int Y_TARGET      = 200,
    parameter int SLIDE_STEP    = 4,
    parameter int BLINK_FRAMES  = 15,
    parameter int BLINK_TOGGLES = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       fin_juego,
    input  logic [2:0] columna,
    input  logic [1:0] ganador,
    output logic       show,
    output logic [1:0] show_player,
    output logic       busy
);
    localparam int GW = 70 << SCALE_LOG2;
    localparam int GH = 30 << SCALE_LOG2;
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int TW = $clog2(BLINK_TOGGLES + 1);

    typedef enum logic [1:0] {IDLE, SLIDE, BLINK, HOLD} state_t;

    state_t        state_q, state_d;
    logic [10:0]   cur_y_q, cur_y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tog_q, tog_d;
    logic          vis_q, vis_d;
    logic [2:0]    col_q, col_d;
    logic [1:0]    win_q, win_d;
    logic          fin_q;
    logic          show_q;
    logic [1:0]    sp_q;

    logic          start;
    logic [9:0]    cx_raw;
    logic [10:0]   cx, x11, y11, dx, dy, y_step;
    logic [6:0]    u, v;
    logic          in_box, e_hit, n_hit, d_hit, show_next;

    assign start = fin_juego & ~fin_q;

    always_comb begin
        state_d = state_q;
        cur_y_d = cur_y_q;
        cnt_d   = cnt_q;
        tog_d   = tog_q;
        vis_d   = vis_q;
        col_d   = col_q;
        win_d   = win_q;
        y_step  = cur_y_q + 11'(SLIDE_STEP);
        if (!fin_juego) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d = SLIDE;
                    col_d   = columna;
                    win_d   = ganador;
                    cur_y_d = '0;
                    vis_d   = 1'b1;
                end
                SLIDE: if (frame_tick) begin
                    if (y_step >= 11'(Y_TARGET)) begin
                        cur_y_d = 11'(Y_TARGET);
                        state_d = BLINK;
                        cnt_d   = '0;
                        tog_d   = '0;
                    end else begin
                        cur_y_d = y_step;
                    end
                end
                BLINK: if (frame_tick) begin
                    if (cnt_q == CW'(BLINK_FRAMES - 1)) begin
                        cnt_d = '0;
                        tog_d = tog_q + 1'b1;
                        if (tog_d == TW'(BLINK_TOGGLES)) begin
                            state_d = HOLD;
                            vis_d   = 1'b1;
                        end else begin
                            vis_d = ~vis_q;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: vis_d = 1'b1;
            endcase
        end
    end

    // Banner left edge, pulled in so a wide glyph never runs past the right border
    always_comb begin
        cx_raw = 10'(int'(col_q) * COL_PITCH + X_OFFSET);
        cx     = ({1'b0, cx_raw} + 11'(GW) > 11'(H_ACTIVE)) ? 11'(H_ACTIVE - GW) : {1'b0, cx_raw};
        x11    = {1'b0, x};
        y11    = {1'b0, y};
        in_box = (x11 >= cx) && (x11 < cx + 11'(GW)) &&
                 (y11 >= cur_y_q) && (y11 < cur_y_q + 11'(GH));
        dx     = x11 - cx;
        dy     = y11 - cur_y_q;
        u      = 7'(dx >> SCALE_LOG2);
        v      = 7'(dy >> SCALE_LOG2);
        e_hit  = (u < 7'd5) ||
                 ((u >= 7'd5) && (u < 7'd15) &&
                  ((v < 7'd3) || ((v >= 7'd11) && (v < 7'd14)) || ((v >= 7'd22) && (v < 7'd30))));
        n_hit  = ((u >= 7'd20) && (u < 7'd25)) || ((u >= 7'd35) && (u < 7'd40)) ||
                 ((u >= 7'd20) && (u < 7'd40) && ((u - 7'd20) == v));
        d_hit  = ((u >= 7'd50) && (u < 7'd55)) ||
                 ((u >= 7'd55) && (u < 7'd65) && ((v < 7'd3) || (v >= 7'd27))) ||
                 ((u >= 7'd65) && (u < 7'd70) && (v >= 7'd3) && (v < 7'd27));
        show_next = (state_q != IDLE) && vis_q && in_box && (e_hit || n_hit || d_hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_y_q <= '0;
            cnt_q   <= '0;
            tog_q   <= '0;
            vis_q   <= 1'b0;
            col_q   <= '0;
            win_q   <= '0;
            fin_q   <= 1'b0;
            show_q  <= 1'b0;
            sp_q    <= '0;
        end else begin
            state_q <= state_d;
            cur_y_q <= cur_y_d;
            cnt_q   <= cnt_d;
            tog_q   <= tog_d;
            vis_q   <= vis_d;
            col_q   <= col_d;
            win_q   <= win_d;
            fin_q   <= fin_juego;
            show_q  <= show_next;
            sp_q    <= show_next ? win_q : 2'd0;
        end
    end

    assign show        = show_q;
    assign show_player = sp_q;
    assign busy        = (state_q == SLIDE) || (state_q == BLINK);
endmodule

// File: tb/tb_winner_banner_anim.sv
// Directed bench for winner_banner_anim: two instances (scale 1x and 2x) share stimulus.
module tb_winner_banner_anim;
    logic       clk = 1'b0;
    logic       rst, frame_tick, fin_juego;
    logic [9:0] x, y;
    logic [2:0] columna;
    logic [1:0] ganador;
    logic       show0, show1, busy0, busy1;
    logic [1:0] sp0, sp1;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    winner_banner_anim #(.SCALE_LOG2(0), .Y_TARGET(8), .SLIDE_STEP(4),
                         .BLINK_FRAMES(2), .BLINK_TOGGLES(2)) dut0 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .x(x), .y(y),
        .fin_juego(fin_juego), .columna(columna), .ganador(ganador),
        .show(show0), .show_player(sp0), .busy(busy0));

    winner_banner_anim #(.SCALE_LOG2(1), .Y_TARGET(8), .SLIDE_STEP(4),
                         .BLINK_FRAMES(2), .BLINK_TOGGLES(2)) dut1 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .x(x), .y(y),
        .fin_juego(fin_juego), .columna(columna), .ganador(ganador),
        .show(show1), .show_player(sp1), .busy(busy1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic px(input int px_x, input int px_y);
        x = 10'(px_x);
        y = 10'(px_y);
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; fin_juego = 1'b1; columna = 3'd2; ganador = 2'd1;
        frame_tick = 1'b0; x = 10'd194; y = 10'd0;
        step(); step();
        checks++; if (show0 !== 1'b0 || sp0 !== 2'd0) begin failures++; $display("FAIL reset_show show=%b sp=%0d want 0/0", show0, sp0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy busy=%b want 0", busy0); end
        rst = 1'b0;
        step();
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL start_after_reset busy=%b want 1", busy0); end
    endtask

    task automatic test_slide();
        px(194, 0);
        checks++; if (show0 !== 1'b1 || sp0 !== 2'd1) begin failures++; $display("FAIL slide_y0 show=%b sp=%0d want 1/1", show0, sp0); end
        pulse_tick();
        px(194, 3);
        checks++; if (show0 !== 1'b0) begin failures++; $display("FAIL slide_y4_above show=%b want 0", show0); end
        px(194, 4);
        checks++; if (show0 !== 1'b1) begin failures++; $display("FAIL slide_y4_top show=%b want 1", show0); end
        pulse_tick();
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL blink_busy busy=%b want 1", busy0); end
        px(194, 7);
        checks++; if (show0 !== 1'b0) begin failures++; $display("FAIL target_above show=%b want 0", show0); end
        px(194, 8);
        checks++; if (show0 !== 1'b1 || sp0 !== 2'd1) begin failures++; $display("FAIL target_hit show=%b sp=%0d want 1/1", show0, sp0); end
        px(199, 12);
        checks++; if (show0 !== 1'b0 || sp0 !== 2'd0) begin failures++; $display("FAIL e_gap show=%b sp=%0d want 0/0", show0, sp0); end
    endtask

    task automatic test_blink();
        x = 10'd194; y = 10'd8;
        pulse_tick(); step();
        checks++; if (show0 !== 1'b1) begin failures++; $display("FAIL blink_t1 show=%b want 1", show0); end
        pulse_tick(); step();
        checks++; if (show0 !== 1'b0 || busy0 !== 1'b1) begin failures++; $display("FAIL blink_t2 show=%b busy=%b want 0/1", show0, busy0); end
        pulse_tick(); step();
        checks++; if (show0 !== 1'b0) begin failures++; $display("FAIL blink_t3 show=%b want 0", show0); end
        pulse_tick();
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL hold_busy busy=%b want 0", busy0); end
        step();
        checks++; if (show0 !== 1'b1) begin failures++; $display("FAIL hold_show show=%b want 1", show0); end
        pulse_tick(); pulse_tick(); step();
        checks++; if (show0 !== 1'b1) begin failures++; $display("FAIL hold_steady show=%b want 1", show0); end
    endtask

    task automatic test_hold_glyph();
        columna = 3'd0; ganador = 2'd2;
        px(194, 8);
        checks++; if (show0 !== 1'b1 || sp0 !== 2'd1) begin failures++; $display("FAIL hold_latch show=%b sp=%0d want 1/1", show0, sp0); end
        px(10, 8);
        checks++; if (show0 !== 1'b0) begin failures++; $display("FAIL hold_newcol show=%b want 0", show0); end
        px(214, 13);
        checks++; if (show0 !== 1'b1) begin failures++; $display("FAIL n_left show=%b want 1", show0); end
        px(211, 18);
        checks++; if (show0 !== 1'b0) begin failures++; $display("FAIL en_gap show=%b want 0", show0); end
        px(224, 18);
        checks++; if (show0 !== 1'b1) begin failures++; $display("FAIL n_diag show=%b want 1", show0); end
        px(224, 19);
        checks++; if (show0 !== 1'b0) begin failures++; $display("FAIL n_offdiag show=%b want 0", show0); end
        px(246, 18);
        checks++; if (show0 !== 1'b1) begin failures++; $display("FAIL d_left show=%b want 1", show0); end
        px(254, 36);
        checks++; if (show0 !== 1'b1) begin failures++; $display("FAIL d_bottom show=%b want 1", show0); end
        px(254, 18);
        checks++; if (show0 !== 1'b0) begin failures++; $display("FAIL d_inner show=%b want 0", show0); end
        px(261, 20);
        checks++; if (show0 !== 1'b1) begin failures++; $display("FAIL d_right show=%b want 1", show0); end
    endtask

    task automatic test_clamp_coincident();
        fin_juego = 1'b0;
        step();
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL hold_abort_busy busy=%b want 0", busy0); end
        px(194, 8);
        checks++; if (show0 !== 1'b0) begin failures++; $display("FAIL hold_abort_show show=%b want 0", show0); end
        fin_juego = 1'b1; columna = 3'd6; ganador = 2'd2; frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL restart_busy busy=%b want 1", busy1); end
        px(500, 0);
        checks++; if (show1 !== 1'b1 || sp1 !== 2'd2) begin failures++; $display("FAIL clamp_edge show=%b sp=%0d want 1/2", show1, sp1); end
        px(499, 0);
        checks++; if (show1 !== 1'b0) begin failures++; $display("FAIL clamp_left show=%b want 0", show1); end
        px(562, 0);
        checks++; if (show0 !== 1'b1) begin failures++; $display("FAIL tick_ignored show=%b want 1", show0); end
        pulse_tick();
        px(500, 4);
        checks++; if (show1 !== 1'b1) begin failures++; $display("FAIL scaled_y4 show=%b want 1", show1); end
        px(510, 4);
        checks++; if (show1 !== 1'b1) begin failures++; $display("FAIL scaled_bar show=%b want 1", show1); end
        px(510, 10);
        checks++; if (show1 !== 1'b0) begin failures++; $display("FAIL scaled_gap show=%b want 0", show1); end
    endtask

    task automatic test_abort_restart();
        fin_juego = 1'b0;
        step();
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL slide_abort_busy busy=%b want 0", busy1); end
        px(500, 4);
        checks++; if (show1 !== 1'b0 || sp1 !== 2'd0) begin failures++; $display("FAIL slide_abort_show show=%b sp=%0d want 0/0", show1, sp1); end
        fin_juego = 1'b1; columna = 3'd0; ganador = 2'd1;
        step();
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL rerun_busy busy=%b want 1", busy0); end
        px(10, 0);
        checks++; if (show0 !== 1'b1 || sp0 !== 2'd1) begin failures++; $display("FAIL rerun_col0 show=%b sp=%0d want 1/1", show0, sp0); end
        checks++; if (show1 !== 1'b1 || sp1 !== 2'd1) begin failures++; $display("FAIL rerun_col0_s1 show=%b sp=%0d want 1/1", show1, sp1); end
    endtask

    initial begin
        test_reset();
        test_slide();
        test_blink();
        test_hold_glyph();
        test_clamp_coincident();
        test_abort_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
